// File: rtl/rvfi_retire_serializer_pkg.sv
// Shared types for the RVFI retire serializer: field widths, the per-retirement
// packet, packet conversion helpers and a lane popcount.
`ifndef RISCV_FORMAL_NRET
`define RISCV_FORMAL_NRET 4
`endif
`ifndef RISCV_FORMAL_XLEN
`define RISCV_FORMAL_XLEN 32
`endif

package rvfi_serializer_pkg;

  localparam int PKG_NRET = `RISCV_FORMAL_NRET;
  localparam int PKG_XLEN = `RISCV_FORMAL_XLEN;
  localparam int MAX_NRET = 4;

  localparam int ORDER_W = 8;
  localparam int INSN_W  = 32;
  localparam int REG_W   = 5;
  localparam int MASK_W  = PKG_XLEN / 8;

  typedef struct packed {
    logic [ORDER_W-1:0]  order;
    logic [INSN_W-1:0]   insn;
    logic                trap;
    logic [REG_W-1:0]    rs1_addr;
    logic [REG_W-1:0]    rs2_addr;
    logic [REG_W-1:0]    rd_addr;
    logic [PKG_XLEN-1:0] rs1_rdata;
    logic [PKG_XLEN-1:0] rs2_rdata;
    logic [PKG_XLEN-1:0] rd_wdata;
    logic [PKG_XLEN-1:0] pc_rdata;
    logic [PKG_XLEN-1:0] pc_wdata;
    logic [PKG_XLEN-1:0] mem_addr;
    logic [MASK_W-1:0]   mem_rmask;
    logic [MASK_W-1:0]   mem_wmask;
    logic [PKG_XLEN-1:0] mem_rdata;
    logic [PKG_XLEN-1:0] mem_wdata;
  } rvfi_pkt_t;

  localparam int PW = $bits(rvfi_pkt_t);

  function automatic logic [PW-1:0] pkt_pack(input rvfi_pkt_t p);
    return p;
  endfunction

  function automatic rvfi_pkt_t pkt_unpack(input logic [PW-1:0] v);
    return v;
  endfunction

  function automatic logic [2:0] popcount(input logic [MAX_NRET-1:0] v);
    logic [2:0] n;
    n = '0;
    for (int i = 0; i < MAX_NRET; i++) n = n + {2'b00, v[i]};
    return n;
  endfunction

endpackage

// File: rtl/rvfi_retire_serializer_if.sv
// Multi-lane RVFI input bundle plus the single-lane serialized output.
interface rvfi_retire_serializer_if
  import rvfi_serializer_pkg::*;
#(
  parameter int NRET = PKG_NRET,
  parameter int XLEN = PKG_XLEN
);
  localparam int MW = XLEN / 8;

  logic [NRET-1:0]         rvfi_valid;
  logic [NRET*ORDER_W-1:0] rvfi_order;
  logic [NRET*INSN_W-1:0]  rvfi_insn;
  logic [NRET-1:0]         rvfi_trap;
  logic [NRET*REG_W-1:0]   rvfi_rs1_addr;
  logic [NRET*REG_W-1:0]   rvfi_rs2_addr;
  logic [NRET*REG_W-1:0]   rvfi_rd_addr;
  logic [NRET*XLEN-1:0]    rvfi_rs1_rdata;
  logic [NRET*XLEN-1:0]    rvfi_rs2_rdata;
  logic [NRET*XLEN-1:0]    rvfi_rd_wdata;
  logic [NRET*XLEN-1:0]    rvfi_pc_rdata;
  logic [NRET*XLEN-1:0]    rvfi_pc_wdata;
  logic [NRET*XLEN-1:0]    rvfi_mem_addr;
  logic [NRET*MW-1:0]      rvfi_mem_rmask;
  logic [NRET*MW-1:0]      rvfi_mem_wmask;
  logic [NRET*XLEN-1:0]    rvfi_mem_rdata;
  logic [NRET*XLEN-1:0]    rvfi_mem_wdata;

  logic                    out_valid;
  logic [ORDER_W-1:0]      out_order;
  logic [INSN_W-1:0]       out_insn;
  logic                    out_trap;
  logic [REG_W-1:0]        out_rs1_addr;
  logic [REG_W-1:0]        out_rs2_addr;
  logic [REG_W-1:0]        out_rd_addr;
  logic [XLEN-1:0]         out_rs1_rdata;
  logic [XLEN-1:0]         out_rs2_rdata;
  logic [XLEN-1:0]         out_rd_wdata;
  logic [XLEN-1:0]         out_pc_rdata;
  logic [XLEN-1:0]         out_pc_wdata;
  logic [XLEN-1:0]         out_mem_addr;
  logic [MW-1:0]           out_mem_rmask;
  logic [MW-1:0]           out_mem_wmask;
  logic [XLEN-1:0]         out_mem_rdata;
  logic [XLEN-1:0]         out_mem_wdata;

  modport master (
    output rvfi_valid, rvfi_order, rvfi_insn, rvfi_trap,
           rvfi_rs1_addr, rvfi_rs2_addr, rvfi_rd_addr,
           rvfi_rs1_rdata, rvfi_rs2_rdata, rvfi_rd_wdata,
           rvfi_pc_rdata, rvfi_pc_wdata, rvfi_mem_addr,
           rvfi_mem_rmask, rvfi_mem_wmask, rvfi_mem_rdata, rvfi_mem_wdata,
    input  out_valid, out_order, out_insn, out_trap,
           out_rs1_addr, out_rs2_addr, out_rd_addr,
           out_rs1_rdata, out_rs2_rdata, out_rd_wdata,
           out_pc_rdata, out_pc_wdata, out_mem_addr,
           out_mem_rmask, out_mem_wmask, out_mem_rdata, out_mem_wdata
  );

  modport slave (
    input  rvfi_valid, rvfi_order, rvfi_insn, rvfi_trap,
           rvfi_rs1_addr, rvfi_rs2_addr, rvfi_rd_addr,
           rvfi_rs1_rdata, rvfi_rs2_rdata, rvfi_rd_wdata,
           rvfi_pc_rdata, rvfi_pc_wdata, rvfi_mem_addr,
           rvfi_mem_rmask, rvfi_mem_wmask, rvfi_mem_rdata, rvfi_mem_wdata,
    output out_valid, out_order, out_insn, out_trap,
           out_rs1_addr, out_rs2_addr, out_rd_addr,
           out_rs1_rdata, out_rs2_rdata, out_rd_wdata,
           out_pc_rdata, out_pc_wdata, out_mem_addr,
           out_mem_rmask, out_mem_wmask, out_mem_rdata, out_mem_wdata
  );

endinterface

// File: rtl/rvfi_retire_serializer_lane_compact.sv
// Packs the valid retire lanes densely in ascending lane order; slot n of the
// output holds the n-th valid lane, and o_k is the number of valid lanes.
module rvfi_lane_compact
  import rvfi_serializer_pkg::*;
#(
  parameter int NRET = PKG_NRET
) (
  input  logic [NRET-1:0]    i_valid,
  input  logic [NRET*PW-1:0] i_lanes,
  output logic [NRET*PW-1:0] o_dense,
  output logic [2:0]         o_k
);

  logic [MAX_NRET-1:0] w_valid_ext;

  assign w_valid_ext = MAX_NRET'(i_valid);
  assign o_k         = popcount(w_valid_ext);

  // A lane's destination slot is the number of valid lanes below it.
  always_comb begin : p_compact
    logic [MAX_NRET-1:0] below;
    logic [2:0]          pos;
    o_dense = '0;
    below   = '0;
    pos     = '0;
    for (int i = 0; i < NRET; i++) begin
      below = w_valid_ext & ((MAX_NRET'(1) << i) - MAX_NRET'(1));
      pos   = popcount(below);
      if (i_valid[i]) o_dense[int'(pos)*PW +: PW] = i_lanes[i*PW +: PW];
    end
  end

endmodule

// File: rtl/rvfi_retire_serializer.sv
// Buffers up to NRET RVFI retirements per cycle and replays them one per cycle,
// flagging dropped cycles (overflow) and non-consecutive rvfi_order (order_error).
module rvfi_retire_serializer
  import rvfi_serializer_pkg::*;
#(
  parameter int NRET  = PKG_NRET,
  parameter int XLEN  = PKG_XLEN,
  parameter int DEPTH = 8
) (
  input  logic                   clock,
  input  logic                   reset,
  rvfi_retire_serializer_if.slave bus,
  output logic [$clog2(DEPTH):0] level,
  output logic                   overflow,
  output logic                   order_error
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;
  localparam int MW = XLEN / 8;

  logic [NRET*PW-1:0] w_lanes;
  logic [NRET*PW-1:0] w_dense;
  logic [2:0]         w_k;
  logic [LW-1:0]      w_k_lw;
  logic [LW-1:0]      w_free;
  logic               w_stored;
  logic               w_push_ok;
  logic               w_drop;
  logic               w_bypass;
  logic               w_pop;
  rvfi_pkt_t          w_head;

  logic [PW-1:0]      r_mem [DEPTH];
  logic [AW-1:0]      r_wr_ptr;
  logic [AW-1:0]      r_rd_ptr;
  logic [LW-1:0]      r_count;
  rvfi_pkt_t          r_out_pkt;
  logic               r_out_valid;
  logic               r_overflow;
  logic               r_order_error;
  logic               r_seeded;
  logic [ORDER_W-1:0] r_exp_order;

  for (genvar i = 0; i < NRET; i++) begin : g_lane
    rvfi_pkt_t w_pkt;
    always_comb begin
      w_pkt.order     = bus.rvfi_order[i*ORDER_W +: ORDER_W];
      w_pkt.insn      = bus.rvfi_insn[i*INSN_W +: INSN_W];
      w_pkt.trap      = bus.rvfi_trap[i];
      w_pkt.rs1_addr  = bus.rvfi_rs1_addr[i*REG_W +: REG_W];
      w_pkt.rs2_addr  = bus.rvfi_rs2_addr[i*REG_W +: REG_W];
      w_pkt.rd_addr   = bus.rvfi_rd_addr[i*REG_W +: REG_W];
      w_pkt.rs1_rdata = bus.rvfi_rs1_rdata[i*XLEN +: XLEN];
      w_pkt.rs2_rdata = bus.rvfi_rs2_rdata[i*XLEN +: XLEN];
      w_pkt.rd_wdata  = bus.rvfi_rd_wdata[i*XLEN +: XLEN];
      w_pkt.pc_rdata  = bus.rvfi_pc_rdata[i*XLEN +: XLEN];
      w_pkt.pc_wdata  = bus.rvfi_pc_wdata[i*XLEN +: XLEN];
      w_pkt.mem_addr  = bus.rvfi_mem_addr[i*XLEN +: XLEN];
      w_pkt.mem_rmask = bus.rvfi_mem_rmask[i*MW +: MW];
      w_pkt.mem_wmask = bus.rvfi_mem_wmask[i*MW +: MW];
      w_pkt.mem_rdata = bus.rvfi_mem_rdata[i*XLEN +: XLEN];
      w_pkt.mem_wdata = bus.rvfi_mem_wdata[i*XLEN +: XLEN];
    end
    assign w_lanes[i*PW +: PW] = pkt_pack(w_pkt);
  end

  rvfi_lane_compact #(.NRET(NRET)) u_compact (
    .i_valid (bus.rvfi_valid),
    .i_lanes (w_lanes),
    .o_dense (w_dense),
    .o_k     (w_k)
  );

  // Free space counts the slot released by this cycle's pop of a stored entry.
  assign w_stored  = (r_count != '0);
  assign w_k_lw    = LW'(w_k);
  assign w_free    = LW'(DEPTH) - (r_count - LW'(w_stored));
  assign w_push_ok = (w_k != 3'd0) && (int'(w_k) <= int'(w_free));
  assign w_drop    = (int'(w_k) > int'(w_free));

  // With nothing stored the oldest incoming lane goes straight to the output;
  // it is still written to the array, but the read pointer skips past it.
  assign w_bypass  = !w_stored && w_push_ok;
  assign w_pop     = w_stored || w_push_ok;
  assign w_head    = w_bypass ? pkt_unpack(w_dense[PW-1:0]) : pkt_unpack(r_mem[r_rd_ptr]);

  always_ff @(posedge clock) begin
    if (w_push_ok) begin
      for (int j = 0; j < NRET; j++) begin
        if (j < int'(w_k)) r_mem[r_wr_ptr + AW'(j)] <= w_dense[j*PW +: PW];
      end
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_wr_ptr      <= '0;
      r_rd_ptr      <= '0;
      r_count       <= '0;
      r_out_pkt     <= '0;
      r_out_valid   <= 1'b0;
      r_overflow    <= 1'b0;
      r_order_error <= 1'b0;
      r_seeded      <= 1'b0;
      r_exp_order   <= '0;
    end else begin
      if (w_push_ok) r_wr_ptr <= r_wr_ptr + AW'(w_k);
      if (w_pop)     r_rd_ptr <= r_rd_ptr + AW'(1);
      r_count     <= r_count + (w_push_ok ? w_k_lw : '0) - LW'(w_pop);
      r_out_valid <= w_pop;
      if (w_pop) begin
        r_out_pkt   <= w_head;
        r_exp_order <= w_head.order + 8'd1;
        r_seeded    <= 1'b1;
        if (r_seeded && (w_head.order != r_exp_order)) r_order_error <= 1'b1;
      end
      if (w_drop) r_overflow <= 1'b1;
    end
  end

  assign level       = r_count;
  assign overflow    = r_overflow;
  assign order_error = r_order_error;

  assign bus.out_valid     = r_out_valid;
  assign bus.out_order     = r_out_pkt.order;
  assign bus.out_insn      = r_out_pkt.insn;
  assign bus.out_trap      = r_out_pkt.trap;
  assign bus.out_rs1_addr  = r_out_pkt.rs1_addr;
  assign bus.out_rs2_addr  = r_out_pkt.rs2_addr;
  assign bus.out_rd_addr   = r_out_pkt.rd_addr;
  assign bus.out_rs1_rdata = r_out_pkt.rs1_rdata;
  assign bus.out_rs2_rdata = r_out_pkt.rs2_rdata;
  assign bus.out_rd_wdata  = r_out_pkt.rd_wdata;
  assign bus.out_pc_rdata  = r_out_pkt.pc_rdata;
  assign bus.out_pc_wdata  = r_out_pkt.pc_wdata;
  assign bus.out_mem_addr  = r_out_pkt.mem_addr;
  assign bus.out_mem_rmask = r_out_pkt.mem_rmask;
  assign bus.out_mem_wmask = r_out_pkt.mem_wmask;
  assign bus.out_mem_rdata = r_out_pkt.mem_rdata;
  assign bus.out_mem_wdata = r_out_pkt.mem_wdata;

endmodule

// File: tb/tb_rvfi_retire_serializer.sv
// Directed bench for rvfi_retire_serializer (NRET=4, XLEN=32, DEPTH=8).
module tb_rvfi_retire_serializer;

  localparam int NRET  = 4;
  localparam int XLEN  = 32;
  localparam int DEPTH = 8;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic [3:0] level;
  logic       overflow;
  logic       order_error;
  int         n_pass  = 0;
  int         n_fail  = 0;
  int         n_total = 0;

  rvfi_retire_serializer_if #(.NRET(NRET), .XLEN(XLEN)) bus ();

  rvfi_retire_serializer #(.NRET(NRET), .XLEN(XLEN), .DEPTH(DEPTH)) dut (
    .clock       (clock),
    .reset       (reset),
    .bus         (bus),
    .level       (level),
    .overflow    (overflow),
    .order_error (order_error)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic idle();
    bus.rvfi_valid = '0;
  endtask

  // Lane i carries order o_i, insn {c0de,00,o_i}, pc_rdata o_i*4.
  task automatic drive(input logic [3:0] v, input logic [7:0] o0, input logic [7:0] o1,
                       input logic [7:0] o2, input logic [7:0] o3);
    logic [7:0] o [4];
    o = '{o0, o1, o2, o3};
    bus.rvfi_valid = v;
    for (int i = 0; i < 4; i++) begin
      bus.rvfi_order[i*8 +: 8]     = o[i];
      bus.rvfi_insn[i*32 +: 32]    = {16'hc0de, 8'h00, o[i]};
      bus.rvfi_pc_rdata[i*32 +: 32] = {22'h0, o[i], 2'b00};
    end
  endtask

  task automatic do_reset();
    idle();
    reset = 1'b1;
    repeat (2) @(posedge clock);
    #1;
    reset = 1'b0;
  endtask

  initial begin
    bus.rvfi_valid     = '0;
    bus.rvfi_order     = '0;
    bus.rvfi_insn      = '0;
    bus.rvfi_trap      = '0;
    bus.rvfi_rs1_addr  = '0;
    bus.rvfi_rs2_addr  = '0;
    bus.rvfi_rd_addr   = '0;
    bus.rvfi_rs1_rdata = '0;
    bus.rvfi_rs2_rdata = '0;
    bus.rvfi_rd_wdata  = '0;
    bus.rvfi_pc_rdata  = '0;
    bus.rvfi_pc_wdata  = '0;
    bus.rvfi_mem_addr  = '0;
    bus.rvfi_mem_rmask = '0;
    bus.rvfi_mem_wmask = '0;
    bus.rvfi_mem_rdata = '0;
    bus.rvfi_mem_wdata = '0;

    repeat (2) @(posedge clock);
    #1;
    chk("rst_level", level, 0);
    chk("rst_out_valid", bus.out_valid, 0);
    chk("rst_overflow", overflow, 0);
    chk("rst_order_error", order_error, 0);
    chk("rst_out_order", bus.out_order, 0);
    reset = 1'b0;

    // single lane, empty FIFO: one-cycle latency
    drive(4'b0001, 8'd5, 8'd0, 8'd0, 8'd0);
    bus.rvfi_insn[31:0] = 32'h00a00093;
    tick();
    chk("t1_valid", bus.out_valid, 1);
    chk("t1_order", bus.out_order, 5);
    chk("t1_insn", bus.out_insn, 32'h00a00093);
    chk("t1_level", level, 0);
    idle();
    tick();
    chk("t1_idle_valid", bus.out_valid, 0);
    chk("t1_hold_order", bus.out_order, 5);

    // gapped lanes 1 and 3
    do_reset();
    drive(4'b1010, 8'd0, 8'd10, 8'd0, 8'd11);
    tick();
    chk("t2_order_a", bus.out_order, 10);
    chk("t2_pc_a", bus.out_pc_rdata, 32'h28);
    chk("t2_level_a", level, 1);
    idle();
    tick();
    chk("t2_valid_b", bus.out_valid, 1);
    chk("t2_order_b", bus.out_order, 11);
    chk("t2_pc_b", bus.out_pc_rdata, 32'h2c);
    chk("t2_order_error", order_error, 0);
    chk("t2_level_b", level, 0);

    // three full-width cycles: third one dropped whole
    do_reset();
    drive(4'b1111, 8'd0, 8'd1, 8'd2, 8'd3);
    tick();
    chk("t3_order_a", bus.out_order, 0);
    chk("t3_level_a", level, 3);
    drive(4'b1111, 8'd4, 8'd5, 8'd6, 8'd7);
    tick();
    chk("t3_order_b", bus.out_order, 1);
    chk("t3_level_b", level, 6);
    chk("t3_overflow_b", overflow, 0);
    drive(4'b1111, 8'd8, 8'd9, 8'd10, 8'd11);
    tick();
    chk("t3_order_c", bus.out_order, 2);
    chk("t3_level_c", level, 5);
    chk("t3_overflow_c", overflow, 1);
    idle();
    for (int i = 3; i < 8; i++) begin
      tick();
      chk("t3_drain_valid", bus.out_valid, 1);
      chk("t3_drain_order", bus.out_order, i);
    end
    tick();
    chk("t3_end_valid", bus.out_valid, 0);
    chk("t3_end_level", level, 0);
    chk("t3_end_order_error", order_error, 0);
    chk("t3_end_overflow", overflow, 1);

    // full FIFO accepts one push alongside the pop
    do_reset();
    drive(4'b1111, 8'd0, 8'd1, 8'd2, 8'd3);
    tick();
    drive(4'b1111, 8'd4, 8'd5, 8'd6, 8'd7);
    tick();
    drive(4'b0111, 8'd8, 8'd9, 8'd10, 8'd0);
    tick();
    chk("t4_full_level", level, 8);
    chk("t4_full_order", bus.out_order, 2);
    drive(4'b0001, 8'd11, 8'd0, 8'd0, 8'd0);
    tick();
    chk("t4_push_level", level, 8);
    chk("t4_push_overflow", overflow, 0);
    chk("t4_push_order", bus.out_order, 3);
    idle();
    for (int i = 4; i < 12; i++) begin
      tick();
      chk("t4_drain_order", bus.out_order, i);
    end
    tick();
    chk("t4_end_valid", bus.out_valid, 0);
    chk("t4_end_level", level, 0);
    chk("t4_end_order_error", order_error, 0);

    // order wrap 255->0 is legal, 0->2 is not
    do_reset();
    drive(4'b0001, 8'd254, 8'd0, 8'd0, 8'd0);
    tick();
    chk("t5_order_254", bus.out_order, 254);
    drive(4'b0001, 8'd255, 8'd0, 8'd0, 8'd0);
    tick();
    chk("t5_order_255", bus.out_order, 255);
    chk("t5_err_255", order_error, 0);
    drive(4'b0001, 8'd0, 8'd0, 8'd0, 8'd0);
    tick();
    chk("t5_order_0", bus.out_order, 0);
    chk("t5_err_wrap", order_error, 0);
    drive(4'b0001, 8'd2, 8'd0, 8'd0, 8'd0);
    tick();
    chk("t5_order_2", bus.out_order, 2);
    chk("t5_err_gap", order_error, 1);
    idle();
    tick();
    chk("t5_err_sticky", order_error, 1);

    // asynchronous reset mid-burst, then reseed
    do_reset();
    drive(4'b1111, 8'd20, 8'd21, 8'd22, 8'd23);
    tick();
    drive(4'b0111, 8'd24, 8'd25, 8'd26, 8'd0);
    tick();
    chk("t6_level_pre", level, 5);
    idle();
    #2 reset = 1'b1;
    #1;
    chk("t6_rst_valid", bus.out_valid, 0);
    chk("t6_rst_level", level, 0);
    chk("t6_rst_overflow", overflow, 0);
    chk("t6_rst_order_error", order_error, 0);
    chk("t6_rst_out_order", bus.out_order, 0);
    @(posedge clock);
    #1;
    reset = 1'b0;
    drive(4'b0001, 8'd40, 8'd0, 8'd0, 8'd0);
    tick();
    chk("t6_valid_40", bus.out_valid, 1);
    chk("t6_order_40", bus.out_order, 40);
    idle();
    tick();
    chk("t6_order_error", order_error, 0);
    chk("t6_end_level", level, 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/rvfi_retire_serializer.md
# rvfi_retire_serializer

Collects up to NRET retirements per cycle from a multi-retire core's RVFI port, buffers them in a FIFO, and replays them one per cycle on a single RVFI channel (NRET=1 view) in retirement order. Sits between the core wrapper and the per-instruction checker so that the checker and its spec models run with NRET=1 regardless of core width. Also flags buffer overflow and out-of-sequence `rvfi_order` on the serialized stream.

## Interface
- NRET, default `RISCV_FORMAL_NRET: input retire lanes per cycle (1..4)
- XLEN, default `RISCV_FORMAL_XLEN: register width (32 or 64)
- DEPTH, default 8: FIFO entries, power of two, DEPTH >= NRET
- Packet fields and per-lane widths: order 8, insn 32, trap 1, rs1_addr/rs2_addr/rd_addr 5, rs1_rdata/rs2_rdata/rd_wdata/pc_rdata/pc_wdata/mem_addr/mem_rdata/mem_wdata XLEN, mem_rmask/mem_wmask XLEN/8. Packet width is PW.

Ports:
- clock  in  1  sole clock, rising edge
- reset  in  1  asynchronous, active-high
- rvfi_valid  in  NRET  per-lane retire valid
- rvfi_<field>  in  NRET*w  every packet field, lane i at [i*w +: w]
- out_valid  out  1  serialized retirement valid
- out_<field>  out  w  every packet field, single lane
- level  out  $clog2(DEPTH)+1  current FIFO occupancy
- overflow  out  1  sticky: a cycle's retirements were dropped
- order_error  out  1  sticky: popped order not previous+1 (mod 256)

## Operation
- Compaction: valid lanes packed in ascending lane index; lane i precedes lane j (i<j) in the FIFO. Gaps (e.g. valid=4'b1010) produce 2 consecutive entries, lane 1 then lane 3.
- Push: k = popcount(rvfi_valid). Written at wr_ptr..wr_ptr+k-1 mod DEPTH when k <= DEPTH - count_after_pop.
- Pop: one entry per cycle whenever count > 0; no backpressure (checker always consumes).
- Capacity uses post-pop count: with count==DEPTH, a pop and a push of 1 in the same cycle both succeed.
- Overflow: k exceeds free space -> all k lanes of that cycle dropped (never partial), overflow set, stays 1 until reset.
- Order tracking: flag seeded=0 at reset. First popped entry loads exp_order = order+1, seeded=1. Each later pop with order != exp_order sets order_error (sticky); exp_order always reloads to popped order+1, 8-bit wrap (255 -> 0 legal).
- After overflow, order_error on the resulting gap is expected and is not suppressed.
- Pointers wrap mod DEPTH; count range 0..DEPTH.

## Timing
- Outputs registered. Entry pushed in cycle t appears on out_* with out_valid=1 in cycle t+1 earliest (empty FIFO); latency = 1 + entries ahead of it.
- out_* field values hold the last popped packet while out_valid=0; checker qualifies on out_valid only.
- Throughput: 1 retirement/cycle out; sustained input above 1/cycle fills FIFO at (k-1)/cycle.
- Reset (async assert, any cycle, including mid-burst): out_valid=0, all out_* = 0, level=0, overflow=0, order_error=0, pointers 0, seeded=0. Deassert synchronously sampled; first push accepted the cycle after deassertion.
- order_error and overflow set on the clock edge that performs the offending pop/push, visible the following cycle.

## Structure
- Package rvfi_serializer_pkg: field width localparams, packet struct (PW bits) with pack/unpack functions, popcount function.
- Sub-module rvfi_lane_compact: combinational prefix-sum compaction of NRET lanes into a dense packet vector plus count k; FIFO, pointers, order tracking and flags in top.
- Storage: DEPTH x PW register array; no RAM inference required.

## Test plan
- NRET=2, single lane 0 valid, order=5, insn=32'h00a00093 -> next cycle out_valid=1, out_order=5, out_insn=32'h00a00093, level returns to 0.
- NRET=4, one cycle valid=4'b1010, orders 10 (lane1), 11 (lane3) -> out_order 10 then 11 on consecutive cycles, order_error=0.
- NRET=4, DEPTH=8, all lanes valid 3 consecutive cycles, orders 0..11 -> first two cycles accepted, third cycle dropped entirely, overflow=1, popped orders 0..7, no partial lanes of the third group.
- FIFO full (level=8) with push of 1 -> accepted via same-cycle pop, overflow stays 0, level stays 8.
- Sequence orders 254, 255, 0, 2 -> wrap 255->0 accepted, order_error rises after popping 2 and stays 1.
- Assert reset with level=5 mid-burst -> out_valid=0, level=0, flags 0 immediately; next pushed order 40 emerges without order_error (reseed).
